// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
// DEFAULT_WIDTH is also the divider's operand width.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The step counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul.sv
// Sequential unsigned shift-add multiply-accumulate: product = A * B + C.
// Consumes one multiplier bit per cycle. Used as the divider's self-check engine.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [WIDTH-1:0]     addend_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state_r;
  state_t           state_s;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    acc_next_s;
  logic [PW-1:0]    a_sh_r;
  logic [PW-1:0]    product_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [CW-1:0]    cnt_r;
  logic             accept_s;
  logic             last_s;

  // Next-state decode and the single accumulate step.
  // A is pre-shifted and B is consumed LSB first, so no variable index is needed.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = (cnt_r == CW'(WIDTH - 1));
    if (b_sh_r[0]) begin
      acc_next_s = acc_r + a_sh_r;
    end else begin
      acc_next_s = acc_r;
    end
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decode the state only, so there is no path from start.
  always_comb begin
    ready   = (state_r != RUN);
    busy    = (state_r == RUN);
    done    = (state_r == DONE);
    product = product_r;
  end

  // State, operand shifters, accumulator and held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= {PW{1'b0}};
      a_sh_r    <= {PW{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {PW{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        a_sh_r <= {{WIDTH{1'b0}}, multiplicand_in};
        b_sh_r <= multiplier_in;
        acc_r  <= {{WIDTH{1'b0}}, addend_in};
        cnt_r  <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        acc_r  <= acc_next_s;
        a_sh_r <= {a_sh_r[PW-2:0], 1'b0};
        b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
        cnt_r  <= cnt_r + CW'(1);
        if (last_s) begin
          product_r <= acc_next_s;
        end else begin
          product_r <= product_r;
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_mul.sv
// Directed self-checking bench for the shift-add multiplier, WIDTH=4.
module tb_mul;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand_in;
  logic [W-1:0] multiplier_in;
  logic [W-1:0] addend_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mul #(.WIDTH(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .multiplicand_in (multiplicand_in),
    .multiplier_in   (multiplier_in),
    .addend_in       (addend_in),
    .ready           (ready),
    .busy            (busy),
    .done            (done),
    .product         (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input int a, input int b, input int c);
    @(negedge clock);
    multiplicand_in = W'(a);
    multiplier_in   = W'(b);
    addend_in       = W'(c);
    start           = 1'b1;
  endtask

  // Counts negedges after the accepting edge until done; bounded at 20.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    @(negedge clock);
    start = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int c, input int exp);
    int lat;
    int bc;
    drive_start(a, b, c);
    wait_done(lat, bc);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int lat;
    int bc;
    int hold_bad;
    int seen_done;
    int q;
    int r;
    int rt_bad;

    reset = 1'b1;
    start = 1'b0;
    multiplicand_in = '0;
    multiplier_in   = '0;
    addend_in       = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_product", 32'(product), 32'd0);

    // 1: basic operation with latency and busy length
    drive_start(13, 11, 2);
    wait_done(lat, bc);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_busy_cycles", 32'(bc), 32'd4);
    check("t1_product", 32'(product), 32'd145);
    check("t1_ready_in_done", 32'(ready), 32'd1);
    @(negedge clock);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clock);
    check("t1_product_held_idle", 32'(product), 32'd145);

    // 2 and 3: maximum and zero operands
    run_op("t2_max", 15, 15, 15, 240);
    run_op("t3_a_zero", 0, 9, 7, 7);
    run_op("t3_b_zero", 9, 0, 0, 0);

    // 4: start with new operands during RUN is ignored
    drive_start(13, 11, 2);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    multiplicand_in = 4'd1;
    multiplier_in   = 4'd1;
    addend_in       = 4'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("t4_latency", 32'(lat), 32'd4);
    check("t4_product", 32'(product), 32'd145);
    @(negedge clock);
    check("t4_ready_after", 32'(ready), 32'd1);
    check("t4_no_second_done", 32'(done), 32'd0);

    // 5: back-to-back, start held high through the DONE cycle
    drive_start(3, 5, 1);
    lat = 0;
    @(negedge clock);
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("t5_first_latency", 32'(lat), 32'd4);
    check("t5_first_product", 32'(product), 32'd16);
    multiplicand_in = 4'd7;
    multiplier_in   = 4'd6;
    addend_in       = 4'd3;
    lat = 0;
    hold_bad = 0;
    @(negedge clock);
    start = 1'b0;
    lat++;
    while (!done && lat < 20) begin
      if (product !== 8'd16) hold_bad++;
      @(negedge clock);
      lat++;
    end
    check("t5_done_spacing", 32'(lat), 32'd5);
    check("t5_hold_first", 32'(hold_bad), 32'd0);
    check("t5_second_product", 32'(product), 32'd45);

    // 6: reset in the second RUN cycle discards the operation
    @(negedge clock);
    drive_start(10, 10, 10);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_product", 32'(product), 32'd0);
    seen_done = 0;
    repeat (8) begin
      if (done) seen_done++;
      @(negedge clock);
    end
    check("t6_no_done", 32'(seen_done), 32'd0);
    run_op("t6_fresh", 6, 7, 5, 47);

    // 7: divider round trip over every legal dividend/divisor pair
    rt_bad = 0;
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        q = dd / dv;
        r = dd % dv;
        drive_start(q, dv, r);
        wait_done(lat, bc);
        if (lat != 4 || product !== 8'(dd)) begin
          rt_bad++;
          if (rt_bad <= 4) $display("FAIL t7_case: dividend %0d divisor %0d got %0d", dd, dv, product);
        end
      end
    end
    check("t7_roundtrip_bad", 32'(rt_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
